// File: rtl/alu_issue_queue.sv
// ALU issue queue: FIFO buffer between an instruction producer and the
// 3-stage pipelined ALU. The head entry is presented to the ALU, which can
// hold it with alu_stall. Issue and stall statistics are kept alongside.
module alu_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [16:0]       in_instr,
  output logic              in_ready,
  input  logic              flush,
  input  logic              alu_stall,
  output logic              issue_valid,
  output logic [1:0]        issue_op,
  output logic [4:0]        issue_dest,
  output logic [4:0]        issue_a,
  output logic [4:0]        issue_b,
  output logic [ADDR_W:0]   level,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

  // Storage is deliberately left without reset.
  logic [16:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [16:0]        head;
  logic               full;
  logic               push;
  logic               pop;
  logic               stall_hit;

  // Handshake qualifiers; a flush cancels both the push and the pop.
  always_comb begin
    full        = (level == LEVEL_FULL);
    in_ready    = ~full;
    issue_valid = (level != {(ADDR_W+1){1'b0}});
    push        = in_valid & in_ready & ~flush;
    pop         = issue_valid & ~alu_stall & ~flush;
    stall_hit   = issue_valid & alu_stall;
  end

  // Present the head entry to the ALU; no same-cycle in->issue bypass.
  always_comb begin
    head       = mem[rd_ptr];
    issue_op   = head[16:15];
    issue_dest = head[14:10];
    issue_a    = head[9:5];
    issue_b    = head[4:0];
  end

  // Write accepted instructions into the storage array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {ADDR_W{1'b0}};
      rd_ptr <= {ADDR_W{1'b0}};
      level  <= {(ADDR_W+1){1'b0}};
    end else if (flush) begin
      wr_ptr <= {ADDR_W{1'b0}};
      rd_ptr <= {ADDR_W{1'b0}};
      level  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue/stall statistics; they survive a flush and wrap on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      if (pop) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (stall_hit) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [16:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        alu_stall;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [4:0]  issue_dest;
  logic [4:0]  issue_a;
  logic [4:0]  issue_b;
  logic [3:0]  level;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [16:0] mq[$];
  logic [15:0] m_issue;
  logic [15:0] m_stall;

  alu_issue_queue #(.DEPTH(8), .ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .alu_stall(alu_stall),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
    .issue_a(issue_a), .issue_b(issue_b), .level(level),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input int op, input int dest, input int a, input int b);
    logic [1:0] o;
    logic [4:0] d, aa, bb;
    o = 2'(op); d = 5'(dest); aa = 5'(a); bb = 5'(b);
    return {o, d, aa, bb};
  endfunction

  task automatic compare_all(input string tag);
    int sz;
    sz = mq.size();
    check_eq({tag, "_level"}, 32'(level), 32'(sz));
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(sz < DEPTH));
    check_eq({tag, "_issue_valid"}, 32'(issue_valid), 32'(sz > 0));
    if (sz > 0) begin
      check_eq({tag, "_head"}, 32'({issue_op, issue_dest, issue_a, issue_b}), 32'(mq[0]));
    end
    check_eq({tag, "_issue_cnt"}, 32'(issue_cnt), 32'(m_issue));
    check_eq({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
  endtask

  // One clock cycle with the given inputs; model advanced by the spec rules.
  task automatic step(input string tag, input logic v, input logic [16:0] ins,
                      input logic fl, input logic st);
    bit do_push, do_pop, do_stall;
    in_valid = v; in_instr = ins; flush = fl; alu_stall = st;
    do_push  = v && (mq.size() < DEPTH) && !fl;
    do_pop   = (mq.size() > 0) && !st && !fl;
    do_stall = (mq.size() > 0) && st;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(ins);
    end
    if (do_pop) m_issue++;
    if (do_stall) m_stall++;
    compare_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_issue = 16'd0;
    m_stall = 16'd0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 17'd0; flush = 1'b0; alu_stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // 1 reset state
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_issue_valid", 32'(issue_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // 2 single push, one-cycle latency, then pop
    step("t2_push", 1'b1, mk(0, 30, 10, 20), 1'b0, 1'b0);
    check_eq("t2_valid", 32'(issue_valid), 32'd1);
    check_eq("t2_fields", 32'({issue_op, issue_dest, issue_a, issue_b}), 32'(mk(0, 30, 10, 20)));
    step("t2_pop", 1'b0, 17'd0, 1'b0, 1'b0);
    check_eq("t2_issue_cnt", 32'(issue_cnt), 32'd1);
    check_eq("t2_level", 32'(level), 32'd0);

    // 3 head held for three stalled cycles
    step("t3_push", 1'b1, mk(1, 16, 15, 20), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("t3_stall", 1'b0, 17'd0, 1'b0, 1'b1);
      check_eq("t3_hold", 32'({issue_op, issue_dest, issue_a, issue_b}), 32'(mk(1, 16, 15, 20)));
    end
    check_eq("t3_stall_cnt", 32'(stall_cnt), 32'd3);
    step("t3_release", 1'b0, 17'd0, 1'b0, 1'b0);
    check_eq("t3_issue_cnt", 32'(issue_cnt), 32'd2);

    // 4 fill to full under stall, refuse a 9th, drain in order
    for (int i = 0; i < 8; i++) step("t4_fill", 1'b1, mk(i % 4, i, i, 31 - i), 1'b0, 1'b1);
    check_eq("t4_full_ready", 32'(in_ready), 32'd0);
    step("t4_ninth", 1'b1, mk(3, 31, 31, 31), 1'b0, 1'b1);
    check_eq("t4_level8", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("t4_order", 32'(issue_a), 32'(i));
      step("t4_drain", 1'b0, 17'd0, 1'b0, 1'b0);
    end

    // 5 simultaneous push/pop at level 3, then at full
    for (int i = 0; i < 3; i++) step("t5_fill3", 1'b1, mk(2, i, 20 + i, i), 1'b0, 1'b1);
    step("t5_pushpop", 1'b1, mk(2, 3, 23, 3), 1'b0, 1'b0);
    check_eq("t5_level3", 32'(level), 32'd3);
    for (int i = 0; i < 5; i++) step("t5_fill8", 1'b1, mk(1, i, 4 + i, i), 1'b0, 1'b1);
    step("t5_full_pop", 1'b1, mk(3, 9, 9, 9), 1'b0, 1'b0);
    check_eq("t5_level7", 32'(level), 32'd7);
    for (int i = 0; i < 7; i++) step("t5_drain", 1'b0, 17'd0, 1'b0, 1'b0);

    // 6 flush with a push in the flush cycle
    for (int i = 0; i < 5; i++) step("t6_fill5", 1'b1, mk(0, i, i, i), 1'b0, 1'b1);
    step("t6_push6", 1'b1, mk(3, 7, 7, 7), 1'b0, 1'b1);
    step("t6_flush", 1'b1, mk(2, 2, 2, 2), 1'b1, 1'b0);
    check_eq("t6_level0", 32'(level), 32'd0);
    check_eq("t6_valid0", 32'(issue_valid), 32'd0);
    for (int i = 0; i < 3; i++) step("t6_after", 1'b0, 17'd0, 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 99) < 60), 17'($urandom),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 35));
    end

    // reset mid-stream: takes effect immediately
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, mk(1, i, i, i), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_valid", 32'(issue_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check_eq("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step("post_rst", 1'($urandom_range(0, 1)), 17'($urandom), 1'b0,
           1'($urandom_range(0, 99) < 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
